// File: rtl/bool_equiv_checker.sv
// Self-driving exhaustive equivalence checker for a two-output Boolean block.
// It walks vec_out through every input combination, compares lhs_in against
// rhs_in once per vector, and reports the mismatch count, the first failing
// vector and an overall pass flag.
//
// Handshake: start is a level sampled on rising edges only while idle or done.
// It launches a sweep, and busy is high for the whole sweep. done then rises
// and stays high, with pass, mismatch_count and first_fail_* stable, until the
// next accepted start or reset. A start seen during a sweep is ignored.
module bool_equiv_checker #(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            lhs_in,
  input  logic            rhs_in,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec,
  output logic [1:0]      dbg_state_o
);

  // The settle counter needs at least one bit, even when no settle cycles are used.
  localparam int CW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYC);
  localparam logic [CW-1:0]   SETTLE_ONE  = CW'(1);
  localparam logic [N_IN-1:0] VEC_LAST    = '1;
  localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE     = (N_IN + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffvec_q, ffvec_d;
  logic            pass_q, pass_d;
  logic [CW-1:0]   settle_q, settle_d;

  logic            sample;
  logic            mism;
  logic [N_IN:0]   cnt_next;

  // Next-state logic: the sweep sequencing, the per-vector compare and result capture.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    pass_d   = pass_q;
    settle_d = settle_q;
    cnt_next = cnt_q;
    sample   = (state_q == S_SWEEP) && (settle_q == SETTLE_LAST);
    mism     = lhs_in ^ rhs_in;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_SWEEP;
          vec_d    = '0;
          cnt_d    = '0;
          ffv_d    = 1'b0;
          ffvec_d  = '0;
          pass_d   = 1'b0;
          settle_d = '0;
        end
      end
      S_SWEEP: begin
        if (!sample) begin
          settle_d = settle_q + SETTLE_ONE;
        end else begin
          // The last compare lands in the count on the same edge that raises done.
          cnt_next = mism ? (cnt_q + CNT_ONE) : cnt_q;
          cnt_d    = cnt_next;
          if (mism && !ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
          end
          if (vec_q == VEC_LAST) begin
            state_d = S_DONE;
            pass_d  = (cnt_next == '0);
          end else begin
            vec_d    = vec_q + VEC_ONE;
            settle_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers. Reset aborts any sweep in progress immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
      pass_q   <= 1'b0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
      pass_q   <= pass_d;
      settle_q <= settle_d;
    end
  end

  assign vec_out          = vec_q;
  assign busy             = (state_q == S_SWEEP);
  assign done             = (state_q == S_DONE);
  assign pass             = pass_q;
  assign mismatch_count   = cnt_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign dbg_state_o      = state_q;

endmodule
